// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounced, mutually exclusive S/R pulse driver with a Q model.
// Optional build macro SR_REDUNDANT_SUPPRESS_EN drops requests that cannot change Q.
module sr_drive_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 1,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req_raw,
    input  logic rst_req_raw,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic q_track
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_PULSE_S = 4'b0010,
        ST_PULSE_R = 4'b0100,
        ST_GAP     = 4'b1000
    } state_t;

    // Bit 0 carries the set request, bit 1 the reset request.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_d;
    logic [1:0]       r_pend;
    logic [CNT_W-1:0] r_dcnt [2];
    logic [1:0]       w_rise;
    logic [1:0]       w_clr;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_conf;
    logic             w_conf;
    logic             r_q;
    logic             w_sup_s;
    logic             w_sup_r;

    assign w_raw  = {rst_req_raw, set_req_raw};
    assign w_rise = r_deb & ~r_deb_d;

`ifdef SR_REDUNDANT_SUPPRESS_EN
    assign w_sup_s = r_q;
    assign w_sup_r = ~r_q;
`else
    assign w_sup_s = 1'b0;
    assign w_sup_r = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_deb_d   <= '0;
            r_dcnt[0] <= '0;
            r_dcnt[1] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + ONE;
                end
            end
        end
    end

    // A fresh rising edge wins over the clear issued on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_rise | (r_pend & ~w_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_conf  <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_conf  <= w_conf;
            if (w_next != r_state || r_state == ST_IDLE) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + ONE;
            end
            if (r_state == ST_IDLE && w_next == ST_PULSE_S) begin
                r_q <= 1'b1;
            end else if (r_state == ST_IDLE && w_next == ST_PULSE_R) begin
                r_q <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 2'b00;
        w_conf = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (&r_pend) begin
                    w_clr  = 2'b11;
                    w_conf = 1'b1;
                end else if (r_pend[0]) begin
                    w_clr[0] = 1'b1;
                    if (!w_sup_s) begin
                        w_next = ST_PULSE_S;
                    end
                end else if (r_pend[1]) begin
                    w_clr[1] = 1'b1;
                    if (!w_sup_r) begin
                        w_next = ST_PULSE_R;
                    end
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (r_pcnt == PULSE_LAST) begin
                    w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_pcnt == GAP_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        S        = (r_state == ST_PULSE_S);
        R        = (r_state == ST_PULSE_R);
        busy     = (r_state != ST_IDLE);
        conflict = r_conf;
        q_track  = r_q;
    end

endmodule
